// File: rtl/sprite_square_renderer.sv
// Draws one chess-piece sprite 1:1 inside a selectable board square. The square
// position changes only at frame_start. The pixel pipeline is latency-matched to an external sync ROM.
module sprite_square_renderer #(
  parameter int          SPRITE_W   = 55,
  parameter int          SPRITE_H   = 55,
  parameter int          ADDR_W     = 12,
  parameter int          IDX_W      = 2,
  parameter int          SQUARE     = 60,
  parameter int          BOARD_X0   = 80,
  parameter int          BOARD_Y0   = 0,
  parameter int          ROM_LAT    = 1,
  parameter int          TRANSP_IDX = 0,
  parameter int          BLINK_LOG2 = 4,
  parameter logic [11:0] HL_RGB     = 12'hFF0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              pos_valid,
  input  logic [2:0]        pos_col,
  input  logic [2:0]        pos_row,
  output logic              pos_ready,
  input  logic              sel,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic              pixel_on,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int X_OFF = (SQUARE - SPRITE_W) / 2;
  localparam int Y_OFF = (SQUARE - SPRITE_H) / 2;

  logic [2:0]            cur_col, cur_row, pend_col, pend_row;
  logic                  pending;
  logic [BLINK_LOG2-1:0] blink_cnt;
  logic [ROM_LAT:0]      v_pipe;
  logic [11:0]           ox, oy, px, py, dx, dy;
  logic                  in_win;
  logic [ADDR_W-1:0]     win_addr;
  logic                  opaque;

  assign pos_ready = ~pending;

  // A request latched while pending is clear waits for the next frame_start,
  // so a same-cycle accept and frame_start commits one frame later.
  // NOTE: state registers use non-blocking assignments so every always_ff
  // block sees the pre-edge values of the others, independent of evaluation order.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_col  <= '0;
      cur_row  <= '0;
      pend_col <= '0;
      pend_row <= '0;
      pending  <= 1'b0;
    end else if (frame_start && pending) begin
      cur_col <= pend_col;
      cur_row <= pend_row;
      pending <= 1'b0;
    end else if (pos_valid && pos_ready) begin
      pend_col <= pos_col;
      pend_row <= pos_row;
      pending  <= 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) blink_cnt <= '0;
    else if (frame_start) blink_cnt <= blink_cnt + 1'b1;
  end

  // Window test in 12-bit unsigned space. dx and dy are meaningful only when in_win is set.
  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    ox     = 12'(BOARD_X0 + X_OFF) + 12'(cur_col) * 12'(SQUARE);
    oy     = 12'(BOARD_Y0 + Y_OFF) + 12'(cur_row) * 12'(SQUARE);
    px     = {2'b00, DrawX};
    py     = {2'b00, DrawY};
    dx     = px - ox;
    dy     = py - oy;
    in_win = (px >= ox) && (px < ox + 12'(SPRITE_W)) &&
             (py >= oy) && (py < oy + 12'(SPRITE_H));
  end

  assign win_addr = ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);

  // Stage 0 plus a valid delay line. v_pipe[ROM_LAT] lines up with rom_q.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      v_pipe      <= '0;
    end else begin
      rom_address <= in_win ? win_addr : '0;
      v_pipe      <= {v_pipe[ROM_LAT-1:0], in_win & blank};
    end
  end

  assign pal_index = rom_q;
  assign opaque    = v_pipe[ROM_LAT] && (rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      pixel_on <= opaque;
      if (!opaque)
        {red, green, blue} <= '0;
      else if (sel && blink_cnt[BLINK_LOG2-1])
        {red, green, blue} <= HL_RGB;
      else
        {red, green, blue} <= {pal_red, pal_green, pal_blue};
    end
  end

endmodule

// File: tb/tb_sprite_square_renderer.sv
// Randomized bench for sprite_square_renderer. A pixel-level reference model computes each
// expected output from board geometry, and a queue aligns it to the pipeline latency.
module tb_sprite_square_renderer;

  localparam int LAT  = 1;
  localparam int SW   = 55;
  localparam int SH   = 55;
  localparam int SQ   = 60;
  localparam int BX0  = 80;
  localparam int BY0  = 0;
  localparam int TIDX = 0;

  logic        vga_clk, reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start, pos_valid, pos_ready, sel;
  logic [2:0]  pos_col, pos_row;
  logic [11:0] rom_address;
  logic [1:0]  rom_q, pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        pixel_on;
  logic [3:0]  red, green, blue;

  sprite_square_renderer #(.ROM_LAT(LAT)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .pos_valid(pos_valid),
    .pos_col(pos_col), .pos_row(pos_row), .pos_ready(pos_ready), .sel(sel),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .pixel_on(pixel_on), .red(red), .green(green), .blue(blue)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // External sync ROM with LAT cycles of read latency and a combinational palette.
  logic [1:0] mem [4096];
  logic [1:0] rq_pipe [LAT];
  logic [3:0] pr [4];
  logic [3:0] pg [4];
  logic [3:0] pb [4];

  always @(posedge vga_clk) begin
    rq_pipe[0] <= mem[rom_address];
    for (int i = 1; i < LAT; i++) rq_pipe[i] <= rq_pipe[i-1];
  end
  assign rom_q     = rq_pipe[LAT-1];
  assign pal_red   = pr[pal_index];
  assign pal_green = pg[pal_index];
  assign pal_blue  = pb[pal_index];

  typedef struct {
    bit          on;
    logic [11:0] rgb;
    int          addr;
  } exp_t;

  exp_t q[$];
  int   n_checks, n_fail;
  int   m_col, m_row, m_pcol, m_prow, m_blink;
  bit   m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int org_x();
    return BX0 + m_col * SQ + (SQ - SW) / 2;
  endfunction

  function automatic int org_y();
    return BY0 + m_row * SQ + (SQ - SH) / 2;
  endfunction

  function automatic exp_t model_pixel(input int x, input int y, input bit b);
    exp_t e;
    int ox, oy, idx;
    bit in;
    ox = org_x();
    oy = org_y();
    in = (x >= ox) && (x < ox + SW) && (y >= oy) && (y < oy + SH);
    e.addr = in ? (y - oy) * SW + (x - ox) : 0;
    idx = int'(mem[e.addr]);
    e.on = in && b && (idx != TIDX);
    if (!e.on) e.rgb = 12'h000;
    else if (sel && m_blink >= 8) e.rgb = 12'hFF0;
    else e.rgb = {pr[idx], pg[idx], pb[idx]};
    return e;
  endfunction

  // The pipeline holds zeros after reset, so LAT+1 zero results are expected before new pixels appear.
  task automatic model_reset();
    exp_t z;
    m_col = 0; m_row = 0; m_pcol = 0; m_prow = 0; m_pend = 0; m_blink = 0;
    z.on = 0; z.rgb = 12'h000; z.addr = 0;
    q.delete();
    repeat (LAT + 1) q.push_back(z);
  endtask

  // Called at a negedge: drives one pixel cycle, advances the model, then checks at the next negedge.
  task automatic step(input int x, input int y, input bit b, input bit fs,
                      input bit pv, input int col, input int row);
    exp_t e;
    DrawX = 10'(x); DrawY = 10'(y); blank = b; frame_start = fs;
    pos_valid = pv; pos_col = 3'(col); pos_row = 3'(row);
    q.push_back(model_pixel(x, y, b));
    if (fs && m_pend) begin
      m_col = m_pcol; m_row = m_prow; m_pend = 0;
    end else if (pv && !m_pend) begin
      m_pcol = col; m_prow = row; m_pend = 1;
    end
    if (fs) m_blink = (m_blink + 1) % 16;
    @(posedge vga_clk);
    @(negedge vga_clk);
    check("rom_address", 32'(rom_address), 32'(q[$].addr));
    check("pos_ready", 32'(pos_ready), 32'(!m_pend));
    if (q.size() == LAT + 2) begin
      e = q.pop_front();
      check("pixel_on", 32'(pixel_on), 32'(e.on));
      check("rgb", 32'({red, green, blue}), 32'(e.rgb));
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    repeat (LAT + 1) idle();
  endtask

  task automatic new_frame();
    flush();
    step(0, 0, 0, 1, 0, 0, 0);
    flush();
  endtask

  task automatic scan_random(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      x = org_x() - 3 + int'($urandom_range(SW + 5));
      y = org_y() - 3 + int'($urandom_range(SH + 5));
      if (y < 0) y = 0;
      step(x, y, ($urandom_range(9) != 0), 0, 0, 0, 0);
    end
    flush();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 2'($urandom_range(3));
    for (int i = 0; i < 4; i++) begin
      pr[i] = 4'($urandom_range(15));
      pg[i] = 4'($urandom_range(15));
      pb[i] = 4'($urandom_range(15));
    end
    pr[2] = 4'hA; pg[2] = 4'h5; pb[2] = 4'h1;
    mem[0] = 2'd2; mem[3024] = 2'd0; mem[1] = 2'd0;
    sel = 0; DrawX = '0; DrawY = '0; blank = 0; frame_start = 0;
    pos_valid = 0; pos_col = '0; pos_row = '0;
    reset_n = 0;
    @(negedge vga_clk);
    check("reset_pixel_on", 32'(pixel_on), 32'd0);
    check("reset_rgb", 32'({red, green, blue}), 32'd0);
    check("reset_pos_ready", 32'(pos_ready), 32'd1);
    check("reset_rom_address", 32'(rom_address), 32'd0);
    @(negedge vga_clk);
    reset_n = 1;
    model_reset();

    // Square (0,0) with origin (82,2). The pixels cover the first and last addresses, both edges, a transparent index, and blank.
    step(82, 2, 1, 0, 0, 0, 0);
    step(136, 56, 1, 0, 0, 0, 0);
    step(81, 2, 1, 0, 0, 0, 0);
    step(137, 2, 1, 0, 0, 0, 0);
    step(83, 2, 1, 0, 0, 0, 0);
    step(82, 2, 0, 0, 0, 0, 0);
    step(82, 1, 1, 0, 0, 0, 0);
    step(82, 57, 1, 0, 0, 0, 0);
    flush();
    scan_random(200);

    // Mid-frame request for (3,5). It holds until frame_start, then the origin becomes (262,302).
    step(90, 10, 1, 0, 1, 3, 5);
    step(91, 10, 1, 0, 1, 6, 6);
    scan_random(60);
    new_frame();
    step(262, 302, 1, 0, 0, 0, 0);
    step(316, 356, 1, 0, 0, 0, 0);
    step(261, 302, 1, 0, 0, 0, 0);
    flush();
    scan_random(150);

    // An accept in the same cycle as frame_start commits only at the following frame.
    step(0, 0, 0, 1, 1, 1, 2);
    flush();
    scan_random(60);
    new_frame();
    scan_random(100);

    // Highlight blink. Phase depends on frame_start count, and the counter ran while sel=0.
    sel = 1;
    for (int f = 0; f < 18; f++) begin
      scan_random(25);
      step(142, 122, 1, 0, 0, 0, 0);
      flush();
      new_frame();
    end

    // Reset mid-line while an opaque pixel is on screen and a request is pending.
    step(0, 0, 0, 0, 1, 4, 4);
    repeat (LAT + 2) step(142, 122, 1, 0, 0, 0, 0);
    check("pre_reset_on", 32'(pixel_on), 32'd1);
    #2;
    reset_n = 0;
    DrawX = '0; DrawY = '0; blank = 0; frame_start = 0; pos_valid = 0;
    #1;
    check("midreset_pixel_on", 32'(pixel_on), 32'd0);
    check("midreset_rgb", 32'({red, green, blue}), 32'd0);
    check("midreset_pos_ready", 32'(pos_ready), 32'd1);
    check("midreset_rom_address", 32'(rom_address), 32'd0);
    @(negedge vga_clk);
    reset_n = 1;
    model_reset();
    repeat (LAT + 3) step(82, 2, 1, 0, 0, 0, 0);
    new_frame();
    scan_random(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
